// File: rtl/udc_sequencer_if.sv
// Command handshake between the microsequencer and udc_sequencer.
// The master drives a command and holds it until ready; the slave accepts on valid & ready.
`timescale 1ns/1ps

interface udc_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int STEPW = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic [STEPW-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        input  cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/udc_sequencer.sv
// Drives mode/preset of an external sync-load up/down counter for exactly N edges per command.
// Optional feature macro: SHADOW_CHECK_EN (shadow count compared against ctr_value while idle).
`timescale 1ns/1ps

module udc_sequencer #(
    parameter int WIDTH = 8,
    parameter int STEPW = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    udc_sequencer_if.slave    cmd,
    output logic [1:0]        ctr_mode,
    output logic [WIDTH-1:0]  ctr_preset,
    input  logic [WIDTH-1:0]  ctr_value,
    output logic              busy,
    output logic              done,
    output logic              mismatch
);

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_DOWN     = 2'b01;
    localparam logic [1:0] OP_UP       = 2'b10;
    localparam logic [1:0] MODE_PRESET = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_UP     = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [STEPW-1:0] rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic             done_q, done_d;

    // The mode chosen at the accept edge is applied to the counter for rem edges;
    // the edge on which rem reaches 1 is the last step and returns the counter to hold.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        preset_d = preset_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    unique case (cmd.cmd_op)
                        OP_LOAD: begin
                            mode_d   = MODE_PRESET;
                            preset_d = cmd.cmd_arg;
                            rem_d    = STEPW'(1);
                            state_d  = RUN;
                        end
                        OP_DOWN, OP_UP: begin
                            if (cmd.cmd_steps != '0) begin
                                mode_d  = cmd.cmd_op;
                                rem_d   = cmd.cmd_steps;
                                state_d = RUN;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            RUN: begin
                rem_d = rem_q - STEPW'(1);
                if (rem_q == STEPW'(1)) begin
                    mode_d  = MODE_HOLD;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            mode_q   <= MODE_HOLD;
            preset_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            mode_q   <= mode_d;
            preset_q <= preset_d;
            done_q   <= done_d;
        end
    end

    assign cmd.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q == RUN);
    assign ctr_mode      = mode_q;
    assign ctr_preset    = preset_q;
    assign done          = done_q;

`ifdef SHADOW_CHECK_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             mismatch_q, mismatch_d;

    // The shadow follows the counter on the same RUN edges; while idle the
    // counter has settled, so any difference is latched until reset.
    always_comb begin
        shadow_d   = shadow_q;
        mismatch_d = mismatch_q;
        if (state_q == RUN) begin
            unique case (mode_q)
                MODE_PRESET: shadow_d = preset_q;
                MODE_UP:     shadow_d = shadow_q + WIDTH'(1);
                MODE_DOWN:   shadow_d = shadow_q - WIDTH'(1);
                default:     shadow_d = shadow_q;
            endcase
        end else if (ctr_value != shadow_q) begin
            mismatch_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q   <= '0;
            mismatch_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_ctr_value;
    assign unused_ctr_value = ^ctr_value;
    assign mismatch         = 1'b0;
`endif

endmodule

// File: tb/tb_udc_sequencer.sv
// Directed bench for udc_sequencer: behavioural counter model, vector table, and
// hand-written sequences for mid-command reset, back-to-back accept and shadow mismatch.
`timescale 1ns/1ps

module tb_udc_sequencer;
    localparam int WIDTH = 8;
    localparam int STEPW = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       ctr_mode;
    logic [WIDTH-1:0] ctr_preset;
    logic [WIDTH-1:0] ctr_value;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] offset = '0;

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    udc_sequencer_if #(.WIDTH(WIDTH), .STEPW(STEPW)) cmd ();

    udc_sequencer #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd        (cmd.slave),
        .ctr_mode   (ctr_mode),
        .ctr_preset (ctr_preset),
        .ctr_value  (ctr_value),
        .busy       (busy),
        .done       (done),
        .mismatch   (mismatch)
    );

    // External MC10E136-style counter: reset = ~reset_n, mode 00 load, 01 down, 10 up, 11 hold.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else begin
            case (ctr_mode)
                2'b00:   cnt <= ctr_preset;
                2'b01:   cnt <= cnt - 8'd1;
                2'b10:   cnt <= cnt + 8'd1;
                default: cnt <= cnt;
            endcase
        end
    end
    assign ctr_value = cnt + offset;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [7:0] arg;
        logic [7:0] steps;
        logic [1:0] exp_mode;
        int         exp_lat;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        else pass_count++;
    endtask

    // Called just after a rising edge with the DUT idle; returns edges from accept to done.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] arg, input logic [7:0] steps,
                                 output int lat, output logic [1:0] mode_seen);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = op;
        cmd.cmd_arg   = arg;
        cmd.cmd_steps = steps;
        @(posedge clk); #1;
        cmd.cmd_valid = 1'b0;
        mode_seen = ctr_mode;
        lat = 0;
        while (!done && lat < 600) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int         lat;
        logic [1:0] mode_seen;
        logic [7:0] exp_preset;
        logic       done_seen;
        logic       exp_mm;

`ifdef SHADOW_CHECK_EN
        exp_mm = 1'b1;
`else
        exp_mm = 1'b0;
`endif
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'b11;
        cmd.cmd_arg   = '0;
        cmd.cmd_steps = '0;
        exp_preset    = 8'h00;

        vecs[0] = '{"load A5",   2'b00, 8'hA5, 8'd0,   2'b00, 1,   8'hA5};
        vecs[1] = '{"load FE",   2'b00, 8'hFE, 8'd0,   2'b00, 1,   8'hFE};
        vecs[2] = '{"up 3 wrap", 2'b10, 8'h00, 8'd3,   2'b10, 3,   8'h01};
        vecs[3] = '{"down 0",    2'b01, 8'h00, 8'd0,   2'b11, 0,   8'h01};
        vecs[4] = '{"nop",       2'b11, 8'h77, 8'd9,   2'b11, 0,   8'h01};
        vecs[5] = '{"down 2",    2'b01, 8'h00, 8'd2,   2'b01, 2,   8'hFF};
        vecs[6] = '{"up 1",      2'b10, 8'h00, 8'd1,   2'b10, 1,   8'h00};
        vecs[7] = '{"load 10",   2'b00, 8'h10, 8'd0,   2'b00, 1,   8'h10};
        vecs[8] = '{"down 16",   2'b01, 8'h00, 8'd16,  2'b01, 16,  8'h00};
        vecs[9] = '{"up 255",    2'b10, 8'h00, 8'd255, 2'b10, 255, 8'hFF};

        #12;
        checkOutput("reset mode", 32'(ctr_mode), 32'h3);
        checkOutput("reset preset", 32'(ctr_preset), 32'h0);
        checkOutput("reset ready", 32'(cmd.cmd_ready), 32'h1);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset mismatch", 32'(mismatch), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].arg, vecs[i].steps, lat, mode_seen);
            if (vecs[i].op == 2'b00) exp_preset = vecs[i].arg;
            checkOutput({vecs[i].name, " mode"}, 32'(mode_seen), 32'(vecs[i].exp_mode));
            checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            checkOutput({vecs[i].name, " counter"}, 32'(cnt), 32'(vecs[i].exp_cnt));
            checkOutput({vecs[i].name, " ready at done"}, 32'(cmd.cmd_ready), 32'h1);
            @(posedge clk); #1;
            checkOutput({vecs[i].name, " done width"}, 32'(done), 32'h0);
            checkOutput({vecs[i].name, " hold after"}, 32'(ctr_mode), 32'h3);
            checkOutput({vecs[i].name, " preset"}, 32'(ctr_preset), 32'(exp_preset));
            checkOutput({vecs[i].name, " mismatch"}, 32'(mismatch), 32'h0);
        end

        // Reset mid-RUN: up 5 interrupted after two steps (counter FF -> 01).
        cmd.cmd_valid = 1'b1; cmd.cmd_op = 2'b10; cmd.cmd_steps = 8'd5;
        @(posedge clk); #1;
        cmd.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("midrun count", 32'(cnt), 32'h01);
        checkOutput("midrun busy", 32'(busy), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset mode", 32'(ctr_mode), 32'h3);
        checkOutput("async reset ready", 32'(cmd.cmd_ready), 32'h1);
        checkOutput("async reset done", 32'(done), 32'h0);
        checkOutput("async reset counter", 32'(cnt), 32'h0);
        checkOutput("async reset preset", 32'(ctr_preset), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen = 1'b1;
        end
        checkOutput("no done after reset", 32'(done_seen), 32'h0);

        // Back-to-back: second command held on cmd_valid while up 4 runs.
        cmd.cmd_valid = 1'b1; cmd.cmd_op = 2'b10; cmd.cmd_steps = 8'd4;
        @(posedge clk); #1;
        cmd.cmd_op = 2'b01; cmd.cmd_steps = 8'd1;
        checkOutput("b2b busy", 32'(busy), 32'h1);
        lat = 0;
        while (!done && lat < 600) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("b2b latency", 32'(lat), 32'd4);
        checkOutput("b2b counter +4", 32'(cnt), 32'h04);
        checkOutput("b2b ready at done", 32'(cmd.cmd_ready), 32'h1);
        @(posedge clk); #1;
        cmd.cmd_valid = 1'b0;
        checkOutput("b2b second accepted", 32'(ctr_mode), 32'h1);
        checkOutput("b2b hold gap", 32'(cnt), 32'h04);
        checkOutput("b2b done dropped", 32'(done), 32'h0);
        @(posedge clk); #1;
        checkOutput("b2b second done", 32'(done), 32'h1);
        checkOutput("b2b second counter", 32'(cnt), 32'h03);
        checkOutput("b2b mismatch", 32'(mismatch), 32'h0);

        // Shadow disagreement while idle must stick until reset.
        @(posedge clk); #1;
        offset = 8'd1;
        @(posedge clk); #1;
        checkOutput("mismatch set", 32'(mismatch), 32'(exp_mm));
        offset = 8'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("mismatch sticky", 32'(mismatch), 32'(exp_mm));
        reset_n = 1'b0;
        #2;
        checkOutput("mismatch cleared", 32'(mismatch), 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
